// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive buffer (package uart_fifo_pkg).
package uart_fifo_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver-side and CPU-side signals of uart_rx_fifo; slave modport is the buffer.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH_BITS = 4
);
    import uart_fifo_pkg::*;

    logic [BYTE_W-1:0]   rx_data;
    logic                rx_interrupt;
    logic                rx_interrupt_clear;
    logic                rd;
    logic [BYTE_W-1:0]   rd_data;
    logic                empty;
    logic                full;
    logic [DEPTH_BITS:0] count;
    logic                overflow;
    logic                overflow_clear;
    logic                irq;

    modport slave (
        input  rx_data, rx_interrupt, rd, overflow_clear,
        output rx_interrupt_clear, rd_data, empty, full, count, overflow, irq
    );

    modport master (
        output rx_data, rx_interrupt, rd, overflow_clear,
        input  rx_interrupt_clear, rd_data, empty, full, count, overflow, irq
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic show-ahead FIFO: head word is presented on rdata_o while not empty.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [DEPTH_BITS:0]   count_o,
    output logic [DEPTH_BITS:0]   count_nxt_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q,  count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == (DEPTH_BITS+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign count_nxt_o = count_d;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart1rx and the CPU: capture FSM, sticky overflow, irq.
// Optional macro UART_RX_FIFO_TIMEOUT_EN adds fill-threshold and idle-timeout irq.
module uart_rx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_BITS    = 4
`ifdef UART_RX_FIFO_TIMEOUT_EN
   ,parameter int unsigned IRQ_THRESHOLD = 8
   ,parameter int unsigned TIMEOUT_BITS  = 8
`endif
) (
    input  logic          clk,
    input  logic          nreset,
    uart_rx_fifo_if.slave bus
);

    cap_state_e          state_q, state_d;
    logic                capture, pop, push, drop;
    logic                fifo_full, fifo_empty;
    logic [DEPTH_BITS:0] fifo_count, fifo_count_nxt;
    logic [BYTE_W-1:0]   fifo_rdata;
    logic                overflow_q, overflow_d;
    logic                irq_q, irq_d;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE:     if (bus.rx_interrupt) state_d = CAPTURE;
            CAPTURE: begin
                capture = 1'b1;
                state_d = WAIT_LOW;
            end
            // Interrupt stays high until the source sees the clear; never re-capture it.
            WAIT_LOW: if (!bus.rx_interrupt) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    assign pop  = bus.rd && !fifo_empty;
    assign push = capture && (!fifo_full || pop);
    assign drop = capture && fifo_full && !pop;

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk         (clk),
        .nreset      (nreset),
        .push_i      (push),
        .wdata_i     (bus.rx_data),
        .pop_i       (pop),
        .rdata_o     (fifo_rdata),
        .count_o     (fifo_count),
        .count_nxt_o (fifo_count_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (bus.overflow_clear) overflow_d = 1'b0;
        if (drop)               overflow_d = 1'b1;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] idle_cnt_q, idle_cnt_d;
    logic                    timeout_q,  timeout_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q + TIMEOUT_BITS'(1);
        timeout_d  = timeout_q || (idle_cnt_q == '1);
        if (push || pop || fifo_empty) begin
            idle_cnt_d = '0;
            timeout_d  = 1'b0;
        end
        irq_d = (32'(fifo_count_nxt) >= IRQ_THRESHOLD) || timeout_d;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`else
    // Registered from the next fill level so irq tracks empty without an extra cycle of lag.
    always_comb irq_d = (fifo_count_nxt != '0);
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.rx_interrupt_clear = capture;
    assign bus.rd_data            = fifo_rdata;
    assign bus.empty              = fifo_empty;
    assign bus.full               = fifo_full;
    assign bus.count              = fifo_count;
    assign bus.overflow           = overflow_q;
    assign bus.irq                = irq_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Buffers received UART bytes between the uart1rx receiver and the CPU bus in main. Consumes uart1rx data/interrupt, acknowledges each byte via interrupt_clear, and stores bytes in a show-ahead FIFO. The CPU pops bytes through a read strobe and is signalled through a level irq. Decouples CPU interrupt latency from line rate; at UART_CLOCK_DIV=8 a byte arrives roughly every 80 clk.

Parameters:
DEPTH_BITS, 4, FIFO depth = 2**DEPTH_BITS entries
IRQ_THRESHOLD, 8, fill level raising irq; used only with UART_RX_FIFO_TIMEOUT_EN
TIMEOUT_BITS, 8, idle-timeout counter width; used only with UART_RX_FIFO_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on rising edge
nreset  in  1  asynchronous, active-low reset
rx_data  in  8  byte from uart1rx data
rx_interrupt  in  1  uart1rx interrupt; level, high while byte pending
rx_interrupt_clear  out  1  one-cycle acknowledge to uart1rx interrupt_clear
rd  in  1  CPU pop strobe, one cycle per byte
rd_data  out  8  FIFO head byte; valid while empty=0
empty  out  1  FIFO holds no bytes
full  out  1  FIFO holds 2**DEPTH_BITS bytes
count  out  DEPTH_BITS+1  current fill level
overflow  out  1  sticky: a byte was dropped
overflow_clear  in  1  clears overflow
irq  out  1  level interrupt to CPU

Behaviour:
- Reset (async, nreset=0): pointers=0, count=0, empty=1, full=0, overflow=0, irq=0, rx_interrupt_clear=0, FSM=IDLE. rd_data content undefined while empty.
- Capture FSM: IDLE -> CAPTURE when rx_interrupt=1. CAPTURE (1 cycle): push rx_data, or if FIFO full and no simultaneous rd, drop byte and set overflow. Drive rx_interrupt_clear=1, go to WAIT_LOW. WAIT_LOW: stay until rx_interrupt=0, then IDLE. This prevents a byte from being captured twice.
- Push latency: rx_interrupt rise at cycle N -> byte written at the edge ending cycle N+1. empty falls and count increments visible at N+2.
- Pop: rd=1 with empty=0 advances head; rd_data shows the next byte the following cycle. rd with empty=1 is ignored: no pointer or count change, no error.
- Simultaneous push and pop: both occur, count unchanged. If full, the push is accepted because the pop frees a slot, and overflow is not set.
- Pointers are DEPTH_BITS wide and wrap modulo depth. count ranges 0..2**DEPTH_BITS. full = (count == 2**DEPTH_BITS).
- overflow_clear and overflow set in the same cycle: set wins.
- irq (macro off): irq = ~empty, registered.
- Reset asserted mid-byte drops buffered contents. FSM returns to IDLE, and a still-high rx_interrupt after reset is captured normally.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN:
- Defined: irq=1 when count >= IRQ_THRESHOLD, or when empty=0 and no push or pop has occurred for 2**TIMEOUT_BITS consecutive cycles.
  - The idle counter resets on any push, pop, or empty FIFO.
  - The timeout irq stays high until the next push or pop.
- Undefined: irq = ~empty. The threshold and timeout logic and their parameters are not instantiated.

Decomposition:
- Package uart_fifo_pkg holds:
  - FSM state encoding (IDLE, CAPTURE, WAIT_LOW)
  - byte width constant (8)
- One natural sub-module: sync_fifo, a generic show-ahead FIFO parameterised on width and DEPTH_BITS, providing push/pop/count/full/empty.
- The capture FSM, overflow flag, and irq logic stay in uart_rx_fifo.

Test Plan:
- Reset, then uart1tx sends 0x5A -> one rx_interrupt_clear pulse, count=1, rd_data=0x5A, irq=1. Pulse rd -> empty=1, irq=0.
- Send 0x01,0x02,0x03 with no reads -> count=3. Three rd pulses return 0x01,0x02,0x03 in order.
- Hold rx_interrupt high 10 cycles with no clear response from the source model -> exactly one byte stored, FSM stays in WAIT_LOW until low.
- Fill 16 bytes (0x00..0x0F), then send 0xAA -> full=1, overflow=1, FIFO contents unchanged. overflow_clear -> overflow=0.
- Full FIFO, rd in the same cycle as the CAPTURE of 0xBB -> count stays 16, overflow=0, last byte read out is 0xBB.
- UART_RX_FIFO_TIMEOUT_EN with TIMEOUT_BITS=4, IRQ_THRESHOLD=8:
  - Push 2 bytes -> irq=0, then irq=1 after 16 idle cycles.
  - Push 8 bytes -> irq=1 immediately.
